// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage that owns the PC, keeps one fetch outstanding and hands PC/instruction to decode.
// Optional build macro FETCH_MISALIGN_CHECK_EN: misaligned redirect/reset targets present a faulted NOP instead of fetching.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_fault
);
    localparam logic [31:0] FAULT_NOP = 32'h0000_0013;

    typedef enum logic [2:0] {BOOT, REQ, WAIT, DROP, OUT} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] instr_q, instr_nxt;
    logic        fault_q, fault_nxt;
    logic        enter_fault;
    logic [31:0] redirect_tgt;
    logic        redirect_bad;
    logic        pc_bad;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign redirect_tgt = redirect_pc;
    assign redirect_bad = (redirect_pc[1:0] != 2'b00);
    assign pc_bad       = (pc[1:0] != 2'b00);
`else
    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
    assign redirect_bad = 1'b0;
    assign pc_bad       = 1'b0;
`endif

    // NOTE: non-blocking assignments here so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= BOOT;
            pc      <= RESET_PC;
            instr_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            instr_q <= instr_nxt;
            fault_q <= fault_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        instr_nxt      = instr_q;
        fault_nxt      = fault_q;
        enter_fault    = 1'b0;
        imem_req_valid = 1'b0;
        imem_req_addr  = pc;

        case (state)
            BOOT: begin
                if (redirect_valid) pc_nxt = redirect_tgt;
                if (redirect_valid ? redirect_bad : pc_bad) enter_fault = 1'b1;
                else                                        state_nxt   = REQ;
            end
            REQ: begin
                if (redirect_valid) begin
                    imem_req_addr = redirect_tgt;
                    pc_nxt        = redirect_tgt;
                end
                if (redirect_valid && redirect_bad) begin
                    enter_fault = 1'b1;
                end else begin
                    imem_req_valid = 1'b1;
                    if (imem_req_ready) state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_nxt = redirect_tgt;
                    // A response arriving with the redirect is stale and simply not captured.
                    if (!imem_rsp_valid)   state_nxt   = DROP;
                    else if (redirect_bad) enter_fault = 1'b1;
                    else                   state_nxt   = REQ;
                end else if (imem_rsp_valid) begin
                    instr_nxt = imem_rsp_data;
                    fault_nxt = 1'b0;
                    state_nxt = OUT;
                end
            end
            DROP: begin
                if (redirect_valid) pc_nxt = redirect_tgt;
                if (imem_rsp_valid) begin
                    if (redirect_valid ? redirect_bad : pc_bad) enter_fault = 1'b1;
                    else                                        state_nxt   = REQ;
                end
            end
            OUT: begin
                if (redirect_valid) begin
                    pc_nxt    = redirect_tgt;
                    fault_nxt = 1'b0;
                    if (redirect_bad) enter_fault = 1'b1;
                    else              state_nxt   = REQ;
                end else if (if_ready) begin
                    pc_nxt    = pc + 32'd4;
                    fault_nxt = 1'b0;
                    state_nxt = REQ;
                end
            end
            default: state_nxt = BOOT;
        endcase

        if (enter_fault) begin
            state_nxt = OUT;
            instr_nxt = FAULT_NOP;
            fault_nxt = 1'b1;
        end
    end

    assign if_valid = (state == OUT);
    assign if_pc    = if_valid ? pc : 32'h0000_0000;
    assign if_instr = instr_q;
    assign if_fault = fault_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed tests for fetch_unit against an architectural-PC model and a latency-programmable memory.
// Define FETCH_MISALIGN_CHECK_EN for both files to exercise the misaligned-target fault path.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] FAULT_NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid, if_ready, if_fault;
    logic [31:0] if_pc, if_instr;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr), .if_fault(if_fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] target(input logic [31:0] a);
`ifdef FETCH_MISALIGN_CHECK_EN
        return a;
`else
        return {a[31:2], 2'b00};
`endif
    endfunction

    function automatic logic misaligned(input logic [31:0] a);
`ifdef FETCH_MISALIGN_CHECK_EN
        return a[1:0] != 2'b00;
`else
        return a[1:0] != a[1:0];
`endif
    endfunction

    // Memory: answers each accepted request rsp_delay cycles later with mem_word(addr).
    int          rsp_delay = 1;
    int          cnt = 0;
    logic [31:0] paddr = '0;
    logic [31:0] req_log[$];

    always @(posedge clk) begin
        if (imem_req_valid && imem_req_ready) begin
            cnt   <= rsp_delay;
            paddr <= imem_req_addr;
            req_log.push_back(imem_req_addr);
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
        end
    end

    always @(negedge clk) begin
        imem_rsp_valid = (cnt == 1);
        imem_rsp_data  = (cnt == 1) ? mem_word(paddr) : 32'hDEAD_BEEF;
    end

    // Architectural model: the PC decode should see next, and whether it is a faulted slot.
    logic [31:0] exp_pc;
    logic        exp_fault;
    int          cycle = 0;
    logic [31:0] del_pc[$];
    logic [31:0] del_instr[$];
    int          del_cycle[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_pc    <= RESET_PC;
            exp_fault <= misaligned(RESET_PC);
        end else begin
            cycle <= cycle + 1;
            if (if_valid && if_ready && !redirect_valid) begin
                del_pc.push_back(if_pc);
                del_instr.push_back(if_instr);
                del_cycle.push_back(cycle);
            end
            if (redirect_valid) begin
                exp_pc    <= target(redirect_pc);
                exp_fault <= misaligned(redirect_pc);
            end else if (if_valid && if_ready) begin
                exp_pc    <= exp_pc + 32'd4;
                exp_fault <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (imem_req_valid)
                check("req_addr", imem_req_addr, redirect_valid ? target(redirect_pc) : exp_pc);
            if (if_valid) begin
                check("if_pc", if_pc, exp_pc);
                check("if_instr", if_instr, exp_fault ? FAULT_NOP : mem_word(exp_pc));
                check("if_fault", {31'b0, if_fault}, {31'b0, exp_fault});
                check("one_outstanding", {31'b0, imem_req_valid}, 32'd0);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
        check({tag, "_req_addr"}, imem_req_addr, RESET_PC);
        check({tag, "_if_valid"}, {31'b0, if_valid}, 32'd0);
        check({tag, "_if_pc"}, if_pc, 32'd0);
        check({tag, "_if_instr"}, if_instr, 32'd0);
        check({tag, "_if_fault"}, {31'b0, if_fault}, 32'd0);
    endtask

    task automatic do_reset(input int delay);
        @(negedge clk);
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b1;
        imem_req_ready = 1'b1;
        rsp_delay      = delay;
        rst_n          = 1'b0;
        @(negedge clk);
        @(negedge clk);
        req_log.delete();
        del_pc.delete();
        del_instr.delete();
        del_cycle.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_del(input int n, input int budget, input string name);
        int start;
        int k;
        start = del_pc.size();
        k = 0;
        while (del_pc.size() < start + n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, del_pc.size() - start, n);
    endtask

    task automatic wait_req(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (req_log.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, req_log.size(), n);
    endtask

    task automatic wait_if_valid(input int budget, input string name);
        int k;
        k = 0;
        while (!if_valid && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, {31'b0, if_valid}, 32'd1);
    endtask

    task automatic pulse_redirect(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    initial begin
        int nreq;
        rst_n          = 1'b1;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b0;
        #1 rst_n = 1'b0;
        #2 check_reset_outputs("reset");

        // Streaming with a zero-wait memory: one instruction every 3 cycles.
        do_reset(1);
        wait_del(4, 40, "t1_deliveries");
        if (del_pc.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t1_req_addr", req_log[i], 32'(4 * i));
                check("t1_del_pc", del_pc[i], 32'(4 * i));
            end
            check("t1_instr1", del_instr[1], 32'h1357_9BDB);
            for (int i = 0; i < 3; i++)
                check("t1_spacing", del_cycle[i+1] - del_cycle[i], 32'd3);
        end

        // Decode stalls for 5 cycles on the second instruction.
        do_reset(1);
        wait_del(1, 20, "t2_first");
        if_ready = 1'b0;
        wait_if_valid(20, "t2_valid");
        nreq = req_log.size();
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", {31'b0, if_valid}, 32'd1);
            check("t2_hold_pc", if_pc, 32'h0000_0004);
            check("t2_hold_instr", if_instr, 32'h1357_9BDB);
            @(negedge clk);
        end
        check("t2_no_req", req_log.size(), nreq);
        if_ready = 1'b1;
        wait_del(1, 10, "t2_release");
        if (del_pc.size() >= 2) check("t2_del_pc", del_pc[1], 32'h0000_0004);

        // Redirect while waiting; the stale response lands two cycles later.
        do_reset(3);
        wait_req(1, 20, "t3_first_req");
        pulse_redirect(32'h8000_0000);
        wait_del(1, 40, "t3_delivery");
        if (del_pc.size() >= 1) begin
            check("t3_del_pc", del_pc[0], 32'h8000_0000);
            check("t3_del_instr", del_instr[0], 32'h9357_9BDF);
            check("t3_req_count", req_log.size(), 32'd2);
            check("t3_req_addr", req_log[1], 32'h8000_0000);
        end

        // Redirect beats if_ready in OUT.
        do_reset(1);
        wait_if_valid(20, "t4_valid");
        pulse_redirect(32'h0000_0100);
        wait_del(1, 20, "t4_delivery");
        if (del_pc.size() >= 1) begin
            check("t4_del_pc", del_pc[0], 32'h0000_0100);
            check("t4_req_addr", req_log[1], 32'h0000_0100);
        end

        // PC wraps from the top of the address space.
        do_reset(1);
        wait_if_valid(20, "t5_valid");
        pulse_redirect(32'hFFFF_FFFC);
        wait_del(2, 30, "t5_delivery");
        if (del_pc.size() >= 2) begin
            check("t5_del_pc0", del_pc[0], 32'hFFFF_FFFC);
            check("t5_del_pc1", del_pc[1], 32'h0000_0000);
            check("t5_req_wrap", req_log[2], 32'h0000_0000);
        end

        // Redirect in BOOT, then reset mid-wait; the late response must be ignored.
        do_reset(3);
        pulse_redirect(32'h0000_0040);
        wait_req(1, 20, "t6_first_req");
        check("t6_boot_redirect", req_log[0], 32'h0000_0040);
        rst_n = 1'b0;
        #1 check_reset_outputs("t6_reset");
        @(negedge clk);
        rst_n = 1'b1;
        wait_del(2, 40, "t6_delivery");
        if (del_pc.size() >= 2) begin
            check("t6_del_pc0", del_pc[0], RESET_PC);
            check("t6_del_instr0", del_instr[0], 32'h1357_9BDF);
            check("t6_del_pc1", del_pc[1], 32'h0000_0004);
        end

        // Misaligned redirect target.
        do_reset(1);
        wait_if_valid(20, "t7_valid");
`ifdef FETCH_MISALIGN_CHECK_EN
        if_ready = 1'b0;
        nreq = req_log.size();
        pulse_redirect(32'h0000_0102);
        check("t7_fault", {31'b0, if_fault}, 32'd1);
        check("t7_pc", if_pc, 32'h0000_0102);
        check("t7_instr", if_instr, FAULT_NOP);
        check("t7_no_req", req_log.size(), nreq);
        if_ready = 1'b1;
        wait_del(2, 20, "t7_delivery");
        if (del_pc.size() >= 2) begin
            check("t7_del_pc1", del_pc[1], 32'h0000_0106);
            check("t7_req_addr", req_log[nreq], 32'h0000_0106);
        end
`else
        pulse_redirect(32'h0000_0102);
        wait_del(1, 20, "t7_delivery");
        if (del_pc.size() >= 1) begin
            check("t7_aligned_pc", del_pc[0], 32'h0000_0100);
            check("t7_aligned_req", req_log[1], 32'h0000_0100);
            check("t7_no_fault", {31'b0, if_fault}, 32'd0);
        end
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

- Instruction fetch stage that owns and writes the program counter.
- Generates sequential (+4) and redirected fetch addresses and issues them to instruction memory over a valid/ready request channel.
- Captures each response and presents PC and instruction to decode with a valid/ready handshake.
- Sits between the branch/jump resolution logic (redirect source) and the decode stage; one fetch outstanding at a time.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  32  fetch address.
- imem_rsp_valid  in  1  instruction returned this cycle.
- imem_rsp_data  in  32  returned instruction.
- redirect_valid  in  1  branch/jump taken; overrides sequential flow.
- redirect_pc  in  32  redirect target.
- if_valid  out  1  if_pc/if_instr valid for decode.
- if_ready  in  1  decode accepts this cycle.
- if_pc  out  32  PC of presented instruction.
- if_instr  out  32  presented instruction.
- if_fault  out  1  misaligned-target fault (see Configuration).

## Operation
- States: BOOT, REQ, WAIT, DROP, OUT.
- Reset: state=BOOT, pc=RESET_PC, if_instr=0, if_fault=0; all outputs 0 except imem_req_addr=RESET_PC.
- BOOT: no request; next cycle -> REQ.
- REQ: imem_req_valid=1; imem_req_addr = redirect_valid ? redirect_pc : pc (combinational). pc<=imem_req_addr. imem_req_ready=1 -> WAIT, else stay REQ. Memory samples the address only on the ready cycle.
- WAIT: imem_rsp_valid=1 -> latch if_instr, -> OUT. redirect_valid=1 -> pc<=redirect_pc; -> REQ if imem_rsp_valid same cycle (response discarded), else -> DROP.
- DROP: discard pending response; imem_rsp_valid=1 -> REQ. Further redirects update pc, stay DROP.
- OUT: if_valid=1, if_pc=pc. redirect_valid=1 -> pc<=redirect_pc, -> REQ, instruction dropped (redirect beats if_ready). Else if_ready=1 -> pc<=pc+4, -> REQ. Else hold all outputs stable.
- pc+4 wraps modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
- imem_rsp_valid outside WAIT/DROP is ignored.
- Redirect in BOOT: pc<=redirect_pc, -> REQ.

## Timing
- Request-to-if_valid latency: 1 cycle after the imem_rsp_valid cycle.
- Zero-wait memory (ready=1, response one cycle after accept, decode always ready): one instruction per 3 cycles (REQ, WAIT, OUT).
- if_valid, if_pc, if_instr, if_fault are registered and never change while if_valid=1 and if_ready=0, except for redirect withdrawal.
- rst_n low at any point (mid-request, mid-wait) returns to BOOT immediately; a late response after reset is ignored.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: redirect_pc[1:0]!=0 produces no memory request. pc<=redirect_pc, -> OUT with if_valid=1, if_fault=1, if_instr=32'h0000_0013. On acceptance, pc<=pc+4 with bits[1:0] preserved and normal fetching resumes; the decoder is responsible for trapping. The same check applies to RESET_PC.
- Not defined: if_fault tied 0; redirect target forced to {redirect_pc[31:2],2'b00}.

## Test plan
- Reset release, ready=1, 1-cycle memory, if_ready=1 -> addresses 0x0, 0x4, 0x8, 0xC; if_valid every 3rd cycle with matching if_pc/if_instr.
- if_ready=0 for 5 cycles in OUT -> if_pc=0x4 and if_instr held stable; no imem request issued.
- Redirect to 0x8000_0000 in WAIT, response 2 cycles later -> response discarded; next request addr 0x8000_0000; if_pc=0x8000_0000.
- Redirect to 0x100 same cycle as if_ready=1 in OUT -> next request 0x100, not pc+4.
- Redirect to 0xFFFF_FFFC, then accept -> next request address 0x0000_0000.
- rst_n pulsed low in WAIT -> outputs return to reset values; fetch restarts at RESET_PC. With FETCH_MISALIGN_CHECK_EN, redirect 0x102 -> if_fault=1, if_pc=0x102, no request issued.
